// File: rtl/board_io_ctrl.sv
// board_io_ctrl: button sync/debounce with press/release pulses, heartbeat, and per-LED mode drivers
module board_io_ctrl #(
   parameter int N_BTN          = 4,
   parameter int N_LED          = 5,
   parameter int DB_CYCLES      = 270000,
   parameter int HB_HALF        = 13500000,
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int LED_ACTIVE_LOW = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_BTN-1:0]   btn_in,
   input  logic [2*N_LED-1:0] led_mode,
   output logic [N_BTN-1:0]   btn_level,
   output logic [N_BTN-1:0]   btn_press,
   output logic [N_BTN-1:0]   btn_release,
   output logic               heartbeat,
   output logic [N_LED-1:0]   led_out
);
   localparam logic [N_BTN-1:0] REL = {N_BTN{BTN_ACTIVE_LOW != 0}};
   localparam logic LAL = LED_ACTIVE_LOW != 0;
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
   localparam int HW = $clog2(HB_HALF + 1);
   localparam logic [HW-1:0] HB_LAST = HW'(HB_HALF - 1);
   logic [N_BTN-1:0] sync1, sync2, s;
   logic [HW-1:0] hb_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= REL;
         sync2 <= REL;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end
   assign s = sync2 ^ REL;
   genvar i, j;
   for (i = 0; i < N_BTN; i++) begin : g_btn
      logic [CW-1:0] cnt;
      logic lvl, prs, rls;
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt <= '0;
            lvl <= 1'b0;
            prs <= 1'b0;
            rls <= 1'b0;
         end else begin
            prs <= 1'b0;
            rls <= 1'b0;
            if (s[i] == lvl) cnt <= '0;
            else if (cnt == DB_LAST) begin
               cnt <= '0;
               lvl <= s[i];
               prs <= s[i];
               rls <= !s[i];
            end else cnt <= cnt + 1'b1;
         end
      end
      assign btn_level[i]   = lvl;
      assign btn_press[i]   = prs;
      assign btn_release[i] = rls;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end else if (hb_cnt == HB_LAST) begin
         hb_cnt    <= '0;
         heartbeat <= !heartbeat;
      end else hb_cnt <= hb_cnt + 1'b1;
   end
   for (j = 0; j < N_LED; j++) begin : g_led
      logic [1:0] mode;
      logic led;
      assign mode = led_mode[2*j +: 2];
      always_ff @(posedge clk)
         led <= reset ? LAL :
                LAL ^ (mode == 2'd0 ? 1'b0 :
                       mode == 2'd1 ? 1'b1 :
                       mode == 2'd2 ? heartbeat : btn_level[j % N_BTN]);
      assign led_out[j] = led;
   end
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed checks of debounce, pulses, heartbeat and LED modes
module tb_board_io_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_in = 4'hF;
   logic [9:0] led_mode = '0;
   logic [3:0] btn_level, btn_press, btn_release;
   logic       heartbeat;
   logic [4:0] led_out;
   int tests = 0;
   int fails = 0;
   int n = 0;

   board_io_ctrl #(
      .N_BTN(4), .N_LED(5), .DB_CYCLES(4), .HB_HALF(3),
      .BTN_ACTIVE_LOW(1), .LED_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .led_mode(led_mode),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .heartbeat(heartbeat), .led_out(led_out)
   );

   always #5 clk = ~clk;
   // edges since the last reset release, for the heartbeat model
   always @(posedge clk) n <= reset ? 0 : n + 1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn_in = 4'hF;
      repeat (3) tick();
      tests++;
      if (btn_level !== 4'b0 || btn_press !== 4'b0 || btn_release !== 4'b0) begin
         fails++;
         $display("FAIL reset_btn level=%b press=%b release=%b exp 0000", btn_level, btn_press, btn_release);
      end
      tests++;
      if (led_out !== 5'b00000 || heartbeat !== 1'b0) begin
         fails++;
         $display("FAIL reset_led led=%b hb=%b exp 00000/0", led_out, heartbeat);
      end
      reset = 1'b0;
   endtask

   task automatic test_press_release();
      btn_in[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         tests++;
         if (btn_level[0] !== (k >= 6) || btn_press[0] !== (k == 6) || btn_release[0] !== 1'b0) begin
            fails++;
            $display("FAIL press edge%0d level=%b press=%b rel=%b exp %b/%b/0", k, btn_level[0], btn_press[0], btn_release[0], k >= 6, k == 6);
         end
      end
      btn_in[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         tests++;
         if (btn_level[0] !== (k < 6) || btn_release[0] !== (k == 6) || btn_press[0] !== 1'b0) begin
            fails++;
            $display("FAIL release edge%0d level=%b rel=%b press=%b exp %b/%b/0", k, btn_level[0], btn_release[0], btn_press[0], k < 6, k == 6);
         end
      end
   endtask

   task automatic test_bounce();
      btn_in[1] = 1'b0;
      repeat (3) tick();
      btn_in[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         tests++;
         if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
            fails++;
            $display("FAIL bounce cyc%0d level=%b press=%b rel=%b exp 0/0/0", k, btn_level[1], btn_press[1], btn_release[1]);
         end
      end
   endtask

   task automatic test_simultaneous();
      btn_in[3:2] = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         tick();
         tests++;
         if (btn_press !== (k == 6 ? 4'b1100 : 4'b0000)) begin
            fails++;
            $display("FAIL simul_press edge%0d press=%b exp %b", k, btn_press, k == 6 ? 4'b1100 : 4'b0000);
         end
      end
      btn_in[3:2] = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         tick();
         tests++;
         if (btn_release !== (k == 6 ? 4'b1100 : 4'b0000)) begin
            fails++;
            $display("FAIL simul_release edge%0d rel=%b exp %b", k, btn_release, k == 6 ? 4'b1100 : 4'b0000);
         end
      end
      tick();
   endtask

   task automatic test_led_modes();
      led_mode = 10'b11_10_01_00_11;
      btn_in[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) begin
            tests++;
            if (btn_level[0] !== 1'b1 || led_out[0] !== 1'b0 || led_out[4] !== 1'b0) begin
               fails++;
               $display("FAIL led_latency level=%b led0=%b led4=%b exp 1/0/0", btn_level[0], led_out[0], led_out[4]);
            end
         end
      end
      tests++;
      if ((led_out & 5'b10111) !== 5'b10101) begin
         fails++;
         $display("FAIL led_static led=%b exp 1x101", led_out);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         tests++;
         if (heartbeat !== 1'((n / 3) % 2) || led_out[3] !== 1'(((n - 1) / 3) % 2)) begin
            fails++;
            $display("FAIL led_hb n=%0d hb=%b led3=%b exp %0d/%0d", n, heartbeat, led_out[3], (n / 3) % 2, ((n - 1) / 3) % 2);
         end
      end
      btn_in[0] = 1'b1;
      repeat (8) tick();
      tests++;
      if (btn_level[0] !== 1'b0 || led_out[0] !== 1'b0 || led_out[4] !== 1'b0) begin
         fails++;
         $display("FAIL led_follow_release level=%b led0=%b led4=%b exp 0/0/0", btn_level[0], led_out[0], led_out[4]);
      end
   endtask

   task automatic test_reset_mid_debounce();
      btn_in[0] = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      repeat (2) begin
         tick();
         tests++;
         if (btn_press !== 4'b0 || btn_level !== 4'b0 || led_out !== 5'b00000) begin
            fails++;
            $display("FAIL midreset press=%b level=%b led=%b exp 0000/0000/00000", btn_press, btn_level, led_out);
         end
      end
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         tests++;
         if (btn_level[0] !== (k >= 6) || btn_press[0] !== (k == 6)) begin
            fails++;
            $display("FAIL postreset edge%0d level=%b press=%b exp %b/%b", k, btn_level[0], btn_press[0], k >= 6, k == 6);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_simultaneous();
      test_led_modes();
      test_reset_mid_debounce();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
